// File: rtl/i2c_read_reg.sv
// Single-byte I2C register reader: writes a register address to a device, then issues a
// repeated-start read of one byte through the shared I2C master and returns it.
module i2c_read_reg #(
    parameter logic [3:0] TIMER_PARAM = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] dev_address,
    input  logic [7:0] reg_address,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       done,
    output logic       busy,
    output logic       message_failure,
    input  logic       timer_exp,
    output logic       timer_start,
    output logic       timer_reset,
    output logic [3:0] timer_param,
    input  logic       i2c_cmd_ready,
    input  logic       i2c_data_out_ready,
    input  logic [7:0] i2c_data_in,
    input  logic       i2c_data_in_valid,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_control,
    input  logic       i2c_bus_active,
    input  logic       i2c_missed_ack,
    output logic [6:0] i2c_dev_address,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_read,
    output logic       i2c_cmd_write,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_valid,
    output logic [7:0] i2c_data_out,
    output logic       i2c_data_out_valid,
    output logic       i2c_data_out_last,
    output logic       i2c_data_in_ready,
    output logic       i2c_control,
    input  logic       i2c_relinquish,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_VALIDATE_BUS = 4'd1,
        S_CMD_WRITE    = 4'd2,
        S_WRITE_ADDR   = 4'd3,
        S_CMD_READ     = 4'd4,
        S_READ_DATA    = 4'd5,
        S_CHECK_FREE   = 4'd6,
        S_DONE         = 4'd7
    } state_e;

    state_e      state_q, state_d;
    logic        first_q, first_d;
    logic        fail_q, fail_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic        timed;

    // States 1..6 run under the external timeout timer.
    assign timed = (state_q inside {S_VALIDATE_BUS, S_CMD_WRITE, S_WRITE_ADDR,
                                    S_CMD_READ, S_READ_DATA, S_CHECK_FREE});

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        fail_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_VALIDATE_BUS;
                    dev_d   = dev_address;
                    reg_d   = reg_address;
                end
            end
            S_VALIDATE_BUS: if (!i2c_bus_busy && !i2c_bus_active) state_d = S_CMD_WRITE;
            S_CMD_WRITE:    if (i2c_cmd_ready) state_d = S_WRITE_ADDR;
            S_WRITE_ADDR:   if (i2c_data_out_ready) state_d = S_CMD_READ;
            S_CMD_READ:     if (i2c_cmd_ready) state_d = S_READ_DATA;
            S_READ_DATA: begin
                if (i2c_data_in_valid) begin
                    state_d = S_CHECK_FREE;
                    data_d  = i2c_data_in;
                end
            end
            S_CHECK_FREE:   if (!i2c_bus_busy && !i2c_bus_control) state_d = S_DONE;
            S_DONE:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase

        // Aborts override the normal transition and never commit a captured byte.
        if (i2c_relinquish) begin
            state_d = S_IDLE;
            data_d  = data_q;
        end else if (state_q != S_IDLE && i2c_missed_ack) begin
            state_d = S_IDLE;
            data_d  = data_q;
            fail_d  = 1'b1;
        end else if (timed && !first_q && timer_exp) begin
            state_d = S_IDLE;
            data_d  = data_q;
            fail_d  = 1'b1;
        end

        first_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            fail_q  <= 1'b0;
            data_q  <= 8'h00;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            fail_q  <= fail_d;
            data_q  <= data_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
        end
    end

    always_comb begin
        busy               = (state_q != S_IDLE);
        i2c_control        = busy;
        state_out          = state_q;
        data               = data_q;
        done               = (state_q == S_DONE);
        data_valid         = done;
        message_failure    = fail_q;
        timer_start        = timed && first_q;
        timer_reset        = timed && first_q;
        timer_param        = busy ? TIMER_PARAM : 4'd0;
        i2c_cmd_valid      = 1'b0;
        i2c_cmd_start      = 1'b0;
        i2c_cmd_write      = 1'b0;
        i2c_cmd_read       = 1'b0;
        i2c_cmd_stop       = 1'b0;
        i2c_dev_address    = 7'h00;
        i2c_data_out       = 8'h00;
        i2c_data_out_valid = 1'b0;
        i2c_data_out_last  = 1'b0;
        i2c_data_in_ready  = 1'b0;
        case (state_q)
            S_CMD_WRITE: begin
                i2c_cmd_valid   = 1'b1;
                i2c_cmd_start   = 1'b1;
                i2c_cmd_write   = 1'b1;
                i2c_dev_address = dev_q;
            end
            S_WRITE_ADDR: begin
                i2c_data_out       = reg_q;
                i2c_data_out_valid = 1'b1;
                i2c_data_out_last  = 1'b1;
            end
            S_CMD_READ: begin
                i2c_cmd_valid   = 1'b1;
                i2c_cmd_start   = 1'b1;
                i2c_cmd_read    = 1'b1;
                i2c_cmd_stop    = 1'b1;
                i2c_dev_address = dev_q;
            end
            S_READ_DATA: i2c_data_in_ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_read_reg.sv
// Bench for i2c_read_reg: per-cycle reference model check, table-driven transactions,
// hand-written abort sequences and a randomized soak.
`timescale 1ns/1ps
module tb_i2c_read_reg;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [6:0] dev_address;
    logic [7:0] reg_address;
    logic [7:0] data;
    logic       data_valid, done, busy, message_failure;
    logic       timer_exp, timer_start, timer_reset;
    logic [3:0] timer_param;
    logic       i2c_cmd_ready, i2c_data_out_ready;
    logic [7:0] i2c_data_in;
    logic       i2c_data_in_valid, i2c_bus_busy, i2c_bus_control, i2c_bus_active;
    logic       i2c_missed_ack;
    logic [6:0] i2c_dev_address;
    logic       i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop, i2c_cmd_valid;
    logic [7:0] i2c_data_out;
    logic       i2c_data_out_valid, i2c_data_out_last, i2c_data_in_ready, i2c_control;
    logic       i2c_relinquish;
    logic [3:0] state_out;

    always #5 clk = ~clk;

    i2c_read_reg dut (
        .clk(clk), .reset(reset), .start(start), .dev_address(dev_address),
        .reg_address(reg_address), .data(data), .data_valid(data_valid), .done(done),
        .busy(busy), .message_failure(message_failure), .timer_exp(timer_exp),
        .timer_start(timer_start), .timer_reset(timer_reset), .timer_param(timer_param),
        .i2c_cmd_ready(i2c_cmd_ready), .i2c_data_out_ready(i2c_data_out_ready),
        .i2c_data_in(i2c_data_in), .i2c_data_in_valid(i2c_data_in_valid),
        .i2c_bus_busy(i2c_bus_busy), .i2c_bus_control(i2c_bus_control),
        .i2c_bus_active(i2c_bus_active), .i2c_missed_ack(i2c_missed_ack),
        .i2c_dev_address(i2c_dev_address), .i2c_cmd_start(i2c_cmd_start),
        .i2c_cmd_read(i2c_cmd_read), .i2c_cmd_write(i2c_cmd_write),
        .i2c_cmd_stop(i2c_cmd_stop), .i2c_cmd_valid(i2c_cmd_valid),
        .i2c_data_out(i2c_data_out), .i2c_data_out_valid(i2c_data_out_valid),
        .i2c_data_out_last(i2c_data_out_last), .i2c_data_in_ready(i2c_data_in_ready),
        .i2c_control(i2c_control), .i2c_relinquish(i2c_relinquish), .state_out(state_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the fixed step list plus the byte last read.
    int         m_phase = 0;
    bit         m_first = 1'b0;
    bit         m_fail  = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [6:0] m_dev   = 7'h00;
    logic [7:0] m_reg   = 8'h00;

    function automatic bit step_ready(input int p);
        case (p)
            0:       return start;
            1:       return !i2c_bus_busy && !i2c_bus_active;
            2, 4:    return i2c_cmd_ready;
            3:       return i2c_data_out_ready;
            5:       return i2c_data_in_valid;
            6:       return !i2c_bus_busy && !i2c_bus_control;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit fl;
        nxt = m_phase;
        fl  = 1'b0;
        if (reset) begin
            nxt    = 0;
            m_data = 8'h00;
        end else if (i2c_relinquish) begin
            nxt = 0;
        end else if (m_phase != 0 && i2c_missed_ack) begin
            nxt = 0;
            fl  = 1'b1;
        end else if (m_phase >= 1 && m_phase <= 6 && !m_first && timer_exp) begin
            nxt = 0;
            fl  = 1'b1;
        end else if (step_ready(m_phase)) begin
            if (m_phase == 0) begin
                m_dev = dev_address;
                m_reg = reg_address;
            end
            if (m_phase == 5) m_data = i2c_data_in;
            nxt = (m_phase == 7) ? 0 : m_phase + 1;
        end
        m_first = !reset && (nxt != m_phase);
        m_fail  = fl;
        m_phase = nxt;
    end

    function automatic logic [14:0] exp_ctl(input int p, input bit first, input bit fl);
        bit cmd, tm;
        cmd = (p == 2) || (p == 4);
        tm  = first && p >= 1 && p <= 6;
        return {p != 0, p == 7, p == 7, fl, tm, tm, cmd, cmd, p == 2, p == 4, p == 4,
                p == 3, p == 3, p == 5, p != 0};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ctl", {busy, done, data_valid, message_failure, timer_start, timer_reset,
                          i2c_cmd_valid, i2c_cmd_start, i2c_cmd_write, i2c_cmd_read,
                          i2c_cmd_stop, i2c_data_out_valid, i2c_data_out_last,
                          i2c_data_in_ready, i2c_control},
                  exp_ctl(m_phase, m_first, m_fail));
            check("state_out", state_out, m_phase);
            check("data", data, m_data);
            check("fields", {i2c_dev_address, i2c_data_out, timer_param},
                  {((m_phase == 2 || m_phase == 4) ? m_dev : 7'h00),
                   ((m_phase == 3) ? m_reg : 8'h00),
                   ((m_phase != 0) ? 4'd1 : 4'd0)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle_inputs();
        start = 0; timer_exp = 0; i2c_cmd_ready = 1; i2c_data_out_ready = 1;
        i2c_data_in_valid = 1; i2c_bus_busy = 0; i2c_bus_control = 0; i2c_bus_active = 0;
        i2c_missed_ack = 0; i2c_relinquish = 0;
    endtask

    task automatic wait_state(input int s, input int budget);
        for (int i = 0; i < budget && state_out != s[3:0]; i++) tick();
        check("reach_state", state_out, s);
    endtask

    typedef struct {
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] rd;
        int         stall;
        int         dly;
        int         exp_lat;
        logic [7:0] exp_data;
    } vec_t;

    // Drives one read with cmd_ready held off `stall` cycles per command state and the
    // read byte `dly` cycles late; checks the done cycle and the captured byte.
    task automatic run_txn(input vec_t v);
        int cnt, lat;
        logic [3:0] prev;
        idle_inputs();
        i2c_data_in = v.rd; dev_address = v.dev; reg_address = v.rg; start = 1;
        prev = 4'd0; cnt = 0; lat = -1;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            tick();
            start = 0;
            dev_address = 7'($urandom);
            reg_address = 8'($urandom);
            if (state_out == prev) cnt++;
            else cnt = 0;
            prev = state_out;
            i2c_cmd_ready     = (cnt >= v.stall);
            i2c_data_in_valid = (cnt >= v.dly);
            if (done) lat = k;
        end
        check("latency", lat, v.exp_lat);
        tick();
        check("txn_data", data, v.exp_data);
        check("txn_idle", {busy, i2c_control}, 2'b00);
    endtask

    vec_t vecs[5];
    int pulses;

    initial begin
        vecs[0] = '{7'h29, 8'h80, 8'h5A, 0, 0, 7, 8'h5A};
        vecs[1] = '{7'h11, 8'h22, 8'hC3, 3, 10, 23, 8'hC3};
        vecs[2] = '{7'h7F, 8'hFF, 8'h00, 1, 2, 11, 8'h00};
        vecs[3] = '{7'h00, 8'h01, 8'hA5, 0, 5, 12, 8'hA5};
        vecs[4] = '{7'h55, 8'hAA, 8'h3C, 2, 0, 11, 8'h3C};

        idle_inputs();
        dev_address = 0; reg_address = 0; i2c_data_in = 0;
        reset = 1;
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        check("rst_state", state_out, 0);
        check("rst_data", data, 8'h00);
        check("rst_outs", {busy, done, data_valid, message_failure, timer_start, i2c_control},
              6'b0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Missed ACK while the register address is being written.
        idle_inputs();
        dev_address = 7'h29; reg_address = 8'h80; i2c_data_in = 8'h77; start = 1;
        tick();
        start = 0;
        wait_state(3, 20);
        i2c_missed_ack = 1;
        tick();
        i2c_missed_ack = 0;
        check("nack_idle", state_out, 0);
        check("nack_fail", message_failure, 1);
        check("nack_ctl", {i2c_control, done}, 2'b00);
        check("nack_data", data, 8'h3C);
        tick();
        check("nack_pulse", message_failure, 0);

        // Timeout with the bus stuck busy; an expiry in the first cycle must be ignored.
        idle_inputs();
        i2c_bus_busy = 1; start = 1;
        tick();
        start = 0;
        check("tmo_first", {state_out, timer_start, timer_reset}, {4'd1, 2'b11});
        timer_exp = 1;
        tick();
        timer_exp = 0;
        check("tmo_ignore_first", state_out, 1);
        pulses = 0;
        for (int k = 2; k <= 6; k++) begin
            if (timer_start || timer_reset) pulses++;
            if (k < 6) tick();
        end
        timer_exp = 1;
        tick();
        timer_exp = 0;
        check("tmo_pulses", pulses, 0);
        check("tmo_idle", state_out, 0);
        check("tmo_fail", message_failure, 1);
        i2c_bus_busy = 0;
        tick();

        // Relinquish in S_READ_DATA with start held high the whole time.
        idle_inputs();
        i2c_data_in_valid = 0; i2c_data_in = 8'h99; start = 1;
        tick();
        wait_state(5, 20);
        i2c_relinquish = 1; start = 0;
        tick();
        i2c_relinquish = 0;
        check("rel_idle", state_out, 0);
        check("rel_outs", {message_failure, i2c_control, i2c_data_in_ready, busy}, 4'b0);
        check("rel_data", data, 8'h3C);

        // Retry, then reset during S_CMD_READ.
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && state_out != 4'd4; i++) begin
            i2c_cmd_ready = (state_out != 4'd3);
            tick();
        end
        check("retry_cmd_read", state_out, 4);
        reset = 1;
        tick();
        reset = 0;
        check("rst_mid_idle", state_out, 0);
        check("rst_mid_outs", {message_failure, i2c_control, i2c_cmd_valid, done}, 4'b0);

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            start              = ($urandom_range(0, 3) == 0);
            dev_address        = 7'($urandom);
            reg_address        = 8'($urandom);
            i2c_data_in        = 8'($urandom);
            i2c_cmd_ready      = ($urandom_range(0, 2) != 0);
            i2c_data_out_ready = ($urandom_range(0, 2) != 0);
            i2c_data_in_valid  = ($urandom_range(0, 2) != 0);
            i2c_bus_busy       = ($urandom_range(0, 3) == 0);
            i2c_bus_control    = ($urandom_range(0, 3) == 0);
            i2c_bus_active     = ($urandom_range(0, 3) == 0);
            i2c_missed_ack     = ($urandom_range(0, 39) == 0);
            timer_exp          = ($urandom_range(0, 19) == 0);
            i2c_relinquish     = ($urandom_range(0, 59) == 0);
            reset              = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle_inputs();
        reset = 0;
        repeat (10) tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
